nios_arch_nios2_qsys_0_oci_dct_packer: RTL and testbench
========================================================

NIOS_ARCH_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: nios_arch_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 Parameter CODE_W, default 2, is the width of one compressed-trace code.
REQ-002 Parameter SLOTS, default 15, is the number of codes per frame; CODE_W*SLOTS = 30.
REQ-003 clk  in  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 code_valid  in  1  indicates that a trace code is offered.
REQ-006 code  in  CODE_W  is the trace code value.
REQ-007 code_ready  out  1  indicates that the packer accepts the offered code this cycle.
REQ-008 flush  in  1  is a single-cycle request to emit a partial frame.
REQ-009 dct_buffer  out  30  is the live packing buffer.
REQ-010 dct_count  out  4  is the number of valid codes in dct_buffer, range 0..15.
REQ-011 frame_valid  out  1  indicates that the frame output register holds a frame.
REQ-012 frame_ready  in  1  is the consumer's acceptance of the frame.
REQ-013 frame_data  out  30  is the emitted frame.
REQ-014 frame_count  out  4  is the number of valid codes in frame_data, range 1..15.
REQ-015 stall_cycles  out  16  is a saturating count of cycles with code_valid=1 and code_ready=0.

Function
REQ-016 A code is accepted when code_valid and code_ready are both 1; on acceptance dct_buffer <= {dct_buffer[27:0], code} and dct_count increments, with the oldest code in the highest occupied slot.
REQ-017 A transfer condition exists when (dct_count==15 or flush_pending with dct_count>0) and (frame_valid==0 or frame_ready==1).
REQ-018 On transfer, frame_data/frame_count load dct_buffer/dct_count and frame_valid is 1 in the next cycle (1-cycle latency from the 15th accept to frame_valid).
REQ-019 On transfer with a simultaneous accept, the buffer becomes {28'b0, code} with dct_count=1; otherwise it becomes 0 with dct_count=0.
REQ-020 code_ready = (dct_count<15) or transfer condition true; a full buffer with a blocked output register stalls input.
REQ-021 frame_valid clears after frame_ready=1 unless a new transfer occurs in the same cycle; frame_data and frame_count stay stable while frame_valid=1 and frame_ready=0.
REQ-022 flush sets flush_pending; flush_pending clears on transfer or when dct_count==0 with no accept in that cycle; a flush with an empty buffer emits no frame.
REQ-023 A flush coincident with an accept includes that code in the flushed frame, which is emitted no earlier than the following cycle.
REQ-024 stall_cycles increments by 1 per stalled cycle and saturates at 16'hFFFF.
REQ-025 Control is a 2-state FSM, FILL (output register empty) and HOLD (frame_valid=1); FILL->HOLD on transfer; HOLD->FILL on frame_ready without transfer; HOLD->HOLD on frame_ready with transfer.

Reset
REQ-026 Under reset, dct_buffer=0, dct_count=0, frame_valid=0, frame_data=0, frame_count=0, flush_pending=0, stall_cycles=0, and the FSM is in FILL.
REQ-027 Reset mid-frame discards both the buffer and the held frame without emitting a frame.
REQ-028 code_ready is 0 during reset.

Structure
REQ-029 CODE_W, SLOTS, the frame width constant and the FILL/HOLD state encoding reside in shared package nios_arch_oci_trace_pkg.
REQ-030 The frame output register with its valid/ready logic is sub-module nios_arch_oci_frame_reg; the packing buffer and counters stay in the top module.

Verification
REQ-031 Stimulus: 15 back-to-back codes 2'b01 with frame_ready=1 -> required response: frame_valid one cycle after the 15th accept, frame_data=30'h15555555, frame_count=15, dct_count=0.
REQ-032 Stimulus: codes 3,2,1 then flush -> required response: frame_data=30'h39, frame_count=3, and no frame on a second flush issued with an empty buffer.
REQ-033 Stimulus: frame_ready=0 while 30 codes are offered continuously -> required response: first frame held stable, buffer fills to 15, code_ready=0, stall_cycles increments each cycle; after frame_ready=1 for one cycle, the second frame is transferred and the accept in that cycle yields dct_count=1.
REQ-034 Stimulus: flush and accept of code 2'b11 at dct_count=4 -> required response: next frame has frame_count=5 with 2'b11 in bits [1:0].
REQ-035 Stimulus: reset asserted at dct_count=7 with frame_valid=1 -> required response: next cycle all outputs zero, no frame emitted.
REQ-036 Stimulus: 70000 stalled cycles -> required response: stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/nios_arch_oci_trace_pkg.sv
// Shared constants and types for the OCI compressed-trace packer: code/frame
// geometry, output-register state encoding and a saturating counter helper.
package nios_arch_oci_trace_pkg;

    localparam int CODE_W  = 2;
    localparam int SLOTS   = 15;
    localparam int FRAME_W = CODE_W * SLOTS;
    localparam int CNT_W   = 4;
    localparam int STALL_W = 16;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } frame_state_e;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] value);
        if (value == {STALL_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/nios_arch_oci_frame_reg.sv
// Frame output register: holds one packed frame under valid/ready handshake.
// FILL means the register is empty, HOLD means a frame is being presented.
module nios_arch_oci_frame_reg
    import nios_arch_oci_trace_pkg::*;
#(
    parameter int FW = FRAME_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [FW-1:0]    load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             frame_ready,
    output logic             frame_valid,
    output logic [FW-1:0]    frame_data,
    output logic [CNT_W-1:0] frame_count,
    output logic             slot_free
);

    frame_state_e     state_r;
    logic [FW-1:0]    frame_data_r;
    logic [CNT_W-1:0] frame_count_r;

    // The register can take a new frame when empty or when the held one leaves now.
    always_comb begin
        slot_free = (state_r == ST_FILL) || frame_ready;
    end

    // Handshake state machine; data only changes on load so it is stable in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_FILL;
            frame_data_r  <= {FW{1'b0}};
            frame_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (load) begin
                        state_r       <= ST_HOLD;
                        frame_data_r  <= load_data;
                        frame_count_r <= load_count;
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    if (frame_ready && load) begin
                        state_r       <= ST_HOLD;
                        frame_data_r  <= load_data;
                        frame_count_r <= load_count;
                    end else if (frame_ready) begin
                        state_r <= ST_FILL;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                end
            endcase
        end
    end

    assign frame_valid = (state_r == ST_HOLD);
    assign frame_data  = frame_data_r;
    assign frame_count = frame_count_r;

endmodule

// File: rtl/nios_arch_nios2_qsys_0_oci_dct_packer.sv
// Packs compressed trace codes into fixed-width frames, emitting full frames
// automatically and partial frames on flush, with input back-pressure.
module nios_arch_nios2_qsys_0_oci_dct_packer
    import nios_arch_oci_trace_pkg::*;
#(
    parameter int CODE_W = nios_arch_oci_trace_pkg::CODE_W,
    parameter int SLOTS  = nios_arch_oci_trace_pkg::SLOTS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       code_valid,
    input  logic [CODE_W-1:0]          code,
    output logic                       code_ready,
    input  logic                       flush,
    output logic [CODE_W*SLOTS-1:0]    dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [CODE_W*SLOTS-1:0]    frame_data,
    output logic [CNT_W-1:0]           frame_count,
    output logic [STALL_W-1:0]         stall_cycles
);

    localparam int FW = CODE_W * SLOTS;

    logic [FW-1:0]      dct_buffer_r;
    logic [CNT_W-1:0]   dct_count_r;
    logic               flush_pending_r;
    logic [STALL_W-1:0] stall_cycles_r;

    logic               slot_free_s;
    logic               full_s;
    logic               xfer_s;
    logic               code_ready_s;
    logic               accept_s;
    logic               pending_clear_s;
    logic [FW-1:0]      buffer_next_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               pending_next_s;

    // Transfer and acceptance decisions for this cycle.
    always_comb begin
        full_s       = (dct_count_r == CNT_W'(SLOTS));
        xfer_s       = (full_s || (flush_pending_r && (dct_count_r != {CNT_W{1'b0}}))) && slot_free_s;
        code_ready_s = !reset && (!full_s || xfer_s);
        accept_s     = code_valid && code_ready_s;
    end

    // Next packing-buffer contents; an accept during transfer starts the new frame.
    always_comb begin
        buffer_next_s = dct_buffer_r;
        count_next_s  = dct_count_r;
        if (xfer_s && accept_s) begin
            buffer_next_s = {{(FW-CODE_W){1'b0}}, code};
            count_next_s  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (xfer_s) begin
            buffer_next_s = {FW{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else if (accept_s) begin
            buffer_next_s = {dct_buffer_r[FW-CODE_W-1:0], code};
            count_next_s  = dct_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            buffer_next_s = dct_buffer_r;
            count_next_s  = dct_count_r;
        end
    end

    // A flush that lands with a transfer plus accept stays pending for the new code.
    always_comb begin
        pending_clear_s = (xfer_s && !(flush && accept_s))
                       || ((dct_count_r == {CNT_W{1'b0}}) && !accept_s);
        pending_next_s  = (flush || flush_pending_r) && !pending_clear_s;
    end

    // Packing buffer, flush request and stall counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer_r    <= {FW{1'b0}};
            dct_count_r     <= {CNT_W{1'b0}};
            flush_pending_r <= 1'b0;
            stall_cycles_r  <= {STALL_W{1'b0}};
        end else begin
            dct_buffer_r    <= buffer_next_s;
            dct_count_r     <= count_next_s;
            flush_pending_r <= pending_next_s;
            if (code_valid && !code_ready_s) begin
                stall_cycles_r <= sat_inc(stall_cycles_r);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    nios_arch_oci_frame_reg #(
        .FW (FW)
    ) u_frame_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (xfer_s),
        .load_data   (dct_buffer_r),
        .load_count  (dct_count_r),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_count (frame_count),
        .slot_free   (slot_free_s)
    );

    assign code_ready   = code_ready_s;
    assign dct_buffer   = dct_buffer_r;
    assign dct_count    = dct_count_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_nios_arch_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the DCT packer: a directed vector table for
// flush behaviour plus hand sequences for full frames, stalls and reset.
module tb_nios_arch_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [1:0]  code;
    logic        code_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cv;
        logic [1:0]  cd;
        logic        fl;
        logic        fr;
        logic        exp_ready;
        logic [3:0]  exp_cnt;
        logic [29:0] exp_buf;
        logic        exp_fv;
        logic [3:0]  exp_fc;
        logic [29:0] exp_fd;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    nios_arch_nios2_qsys_0_oci_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .code_valid   (code_valid),
        .code         (code),
        .code_ready   (code_ready),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_count  (frame_count),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [1:0] cd, input logic fl, input logic fr);
        code_valid  = cv;
        code        = cd;
        flush       = fl;
        frame_ready = fr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        code_valid = 1'b0; code = 2'd0; flush = 1'b0; frame_ready = 1'b0;

        // cv cd fl fr | ready cnt buf fv fc fd
        vecs[0]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 4'd1, 30'h3,  1'b0, 4'd0, 30'h0};
        vecs[1]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'd2, 30'hE,  1'b0, 4'd0, 30'h0};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'd3, 30'h39, 1'b0, 4'd0, 30'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd3, 30'h39, 1'b0, 4'd0, 30'h0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 30'h0,  1'b1, 4'd3, 30'h39};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'd1, 30'h0,  1'b0, 4'd0, 30'h0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'd2, 30'h1,  1'b0, 4'd0, 30'h0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'd3, 30'h6,  1'b0, 4'd0, 30'h0};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 4'd4, 30'h1B, 1'b0, 4'd0, 30'h0};
        vecs[13] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'd5, 30'h6F, 1'b0, 4'd0, 30'h0};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 30'h0,  1'b1, 4'd5, 30'h6F};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 30'h0,  1'b1, 4'd5, 30'h6F};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 30'h0,  1'b0, 4'd0, 30'h0};

        // Reset state
        do_reset();
        chk("rst_cnt", 32'(dct_count), 32'd0);
        chk("rst_buf", 32'(dct_buffer), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_fd", 32'(frame_data), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);

        // Flush table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].cv, vecs[i].cd, vecs[i].fl, vecs[i].fr);
            chk($sformatf("v%0d_ready", i), 32'(code_ready), 32'(vecs[i].exp_ready));
            tick();
            chk($sformatf("v%0d_cnt", i), 32'(dct_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_buf", i), 32'(dct_buffer), 32'(vecs[i].exp_buf));
            chk($sformatf("v%0d_fv", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
            if (vecs[i].exp_fv) begin
                chk($sformatf("v%0d_fc", i), 32'(frame_count), 32'(vecs[i].exp_fc));
                chk($sformatf("v%0d_fd", i), 32'(frame_data), 32'(vecs[i].exp_fd));
            end
        end

        // Full frame of fifteen 2'b01 codes
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b1);
            tick();
        end
        chk("full_cnt15", 32'(dct_count), 32'd15);
        chk("full_fv_early", 32'(frame_valid), 32'd0);
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        chk("full_fv", 32'(frame_valid), 32'd1);
        chk("full_fd", 32'(frame_data), 32'h15555555);
        chk("full_fc", 32'(frame_count), 32'd15);
        chk("full_cnt0", 32'(dct_count), 32'd0);

        // Back-pressure: 30 codes with the consumer blocked
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'd2, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'd3, 1'b0, 1'b0);
            tick();
        end
        chk("bp_cnt15", 32'(dct_count), 32'd15);
        chk("bp_fv", 32'(frame_valid), 32'd1);
        chk("bp_stall0", 32'(stall_cycles), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 2'd3, 1'b0, 1'b0);
            chk("bp_ready0", 32'(code_ready), 32'd0);
            tick();
            chk("bp_stall", 32'(stall_cycles), 32'(i));
            chk("bp_fd_stable", 32'(frame_data), 32'h2AAAAAAA);
            chk("bp_fc_stable", 32'(frame_count), 32'd15);
        end
        drive(1'b1, 2'd3, 1'b0, 1'b1);
        chk("bp_ready1", 32'(code_ready), 32'd1);
        tick();
        chk("bp_fd2", 32'(frame_data), 32'h3FFFFFFF);
        chk("bp_fv2", 32'(frame_valid), 32'd1);
        chk("bp_cnt1", 32'(dct_count), 32'd1);
        chk("bp_buf1", 32'(dct_buffer), 32'd3);
        chk("bp_stall_hold", 32'(stall_cycles), 32'd5);

        // Reset with count 7 and a frame held
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 2'd2, 1'b0, 1'b0);
            tick();
        end
        chk("mid_cnt7", 32'(dct_count), 32'd7);
        chk("mid_fv", 32'(frame_valid), 32'd1);
        reset = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("mid_ready_rst", 32'(code_ready), 32'd0);
        tick();
        chk("mid_cnt", 32'(dct_count), 32'd0);
        chk("mid_buf", 32'(dct_buffer), 32'd0);
        chk("mid_fv0", 32'(frame_valid), 32'd0);
        chk("mid_fd", 32'(frame_data), 32'd0);
        chk("mid_fc", 32'(frame_count), 32'd0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        tick();
        chk("mid_no_frame", 32'(frame_valid), 32'd0);

        // Stall counter saturation
        do_reset();
        for (int i = 0; i < 70030; i++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b0);
            tick();
        end
        chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
        chk("sat_ready", 32'(code_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
